instr_mem_dp: RTL and testbench
===============================

Name: instr_mem_dp

Overview:
- Parametrised dual-read, dual-write instruction memory for the pipeline fetch stage.
- Successor to the fixed 64x16 instruction store, with parametrised width and depth.
- Reads are registered with a valid strobe.
- Initialisation is a sequential fill state machine instead of a reset-time loop.
- Provides a ready flag, write-collision detection and out-of-range handling.

Parameters:
- DATA_W, 16, instruction word width in bits.
- ADDR_W, 6, address width in bits.
- DEPTH, 64, number of words; DEPTH <= 2**ADDR_W.
- INIT_VALUE, 1, word written to every location during the fill; truncated to DATA_W.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- rd1_req  in  1  read request, port 1.
- rd1_addr  in  ADDR_W  read address, port 1.
- rd1_data  out  DATA_W  registered read data, port 1.
- rd1_valid  out  1  one-cycle pulse, rd1_data updated.
- rd2_req, rd2_addr, rd2_data, rd2_valid  as port 1, port 2.
- wr1_en  in  1  write enable, port 1.
- wr1_addr  in  ADDR_W  write address, port 1.
- wr1_data  in  DATA_W  write data, port 1.
- wr2_en, wr2_addr, wr2_data  as port 1, port 2.
- ready  out  1  memory initialised; requests accepted.
- wr_collision  out  1  registered pulse: both writes hit the same address.

Behaviour:
- Reset asserted (reset=0), asynchronous:
  - rd1_data=0, rd2_data=0, rd1_valid=0, rd2_valid=0, ready=0, wr_collision=0.
  - State=FILL, fill pointer=0.
  - Array contents are not reset directly.
- State machine:
  - FILL: each cycle writes INIT_VALUE to the fill pointer and increments it. After writing DEPTH-1, next state is RUN and ready=1 from the following cycle. Fill takes exactly DEPTH cycles after reset deassertion.
  - RUN: normal operation. Stays in RUN until reset.
- Reset during FILL or RUN aborts immediately; the fill restarts from address 0.
- In FILL, all rd*_req and wr*_en are ignored: no write, no valid pulse, no collision flag.
- Read (RUN, rdN_req=1):
  - Address sampled at edge k; rdN_data and rdN_valid=1 appear after edge k (1-cycle latency).
  - rdN_valid returns to 0 the next cycle unless a new request is made.
  - rdN_data holds its value until the next accepted read.
  - Back-to-back requests on every cycle are supported, one result per cycle.
- Write (RUN, wrN_en=1): the array is updated at the clock edge.
- Same-address writes: wr1_en & wr2_en & (wr1_addr==wr2_addr):
  - Port 2 data is stored; port 1 is dropped.
  - wr_collision=1 for one cycle after that edge.
  - Different addresses: both are stored.
- Read and write to the same address in the same cycle: read returns the old contents (read-before-write), unless the optional feature is enabled.
- Out-of-range address (addr >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - Write ignored.
  - Read returns 0 with rdN_valid=1.
  - A collision is not flagged when both writes are out of range.
- Both read ports may access the same address simultaneously; both return the same data.

Optional Feature:
- Macro: INSTR_MEM_BYPASS_EN.
- Defined: a read hitting an address written in the same cycle returns the newly written data. When both writes hit that address, port 2 data is returned.
- Undefined: read-before-write as specified above; no bypass muxes are generated.

Decomposition:
- Shared package/include `instr_mem_pkg`:
  - State encodings ST_FILL=1'b0, ST_RUN=1'b1.
  - Default DATA_W/ADDR_W/DEPTH constants.
  - INIT_VALUE default.
- One natural sub-module, `instr_mem_rd_port`: holds the registered data/valid logic and the out-of-range zeroing. It is instantiated twice.
- The array, fill FSM and write/collision logic stay in the top level.

Test Plan:
- Release reset; hold all requests -> ready=0 for 64 cycles, ready=1 on cycle 65. Then read addresses 0, 31 and 63 -> each returns 16'h0001 with valid one cycle after the request.
- RUN: wr1 addr 5 = 16'hABCD and wr2 addr 5 = 16'h1234 in the same cycle -> wr_collision pulses once. A subsequent read of addr 5 returns 16'h1234.
- RUN: write addr 9 = 16'h00FF while rd1 reads addr 9 in the same cycle:
  - Feature off: returns 16'h0001.
  - INSTR_MEM_BYPASS_EN: returns 16'h00FF.
  - A read on the next cycle returns 16'h00FF in both builds.
- DEPTH=40, ADDR_W=6: write addr 50 = 16'hBEEF, then read addr 50 -> rd_valid=1, data 0. Addresses 0-39 are unchanged.
- Assert reset at fill cycle 20, release, and issue reads during the fill -> no rd_valid pulses, ready is low for a full 64 cycles after release, and all locations read as 16'h0001.
- RUN: read requests on both ports every cycle over 10 cycles to addresses 0..9 -> 10 consecutive valid pulses per port with matching data, and rd data held after the last request.

Source files
------------

// File: rtl/instr_mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : instr_mem_pkg                                           |
// | Brief  : Shared state encodings and default geometry for the     |
// |          dual-port instruction memory.                           |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package instr_mem_pkg;

  // Fill FSM states: FILL walks the array writing the init word, RUN serves ports.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 6;
  localparam int DEF_DEPTH      = 64;
  localparam int DEF_INIT_VALUE = 1;

endpackage : instr_mem_pkg
`default_nettype wire

// File: rtl/instr_mem_rd_port.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : instr_mem_rd_port                                       |
// | Brief  : Registered read data/valid for one read port; returns   |
// |          zero for addresses beyond the populated depth.          |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module instr_mem_rd_port
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              accept,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  logic              w_in_range;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  assign w_in_range = ({1'b0, addr} < c_depth);

  // Capture the word on an accepted request; data holds between requests.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= accept;
      if (accept) begin
        r_data <= w_in_range ? word : '0;
      end
    end
  end

  assign data  = r_data;
  assign valid = r_valid;

endmodule : instr_mem_rd_port
`default_nettype wire

// File: rtl/instr_mem_dp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : instr_mem_dp                                            |
// | Brief  : Dual-read, dual-write instruction memory with a         |
// |          sequential init fill, registered reads, write-collision |
// |          flag and out-of-range handling.                         |
// |          Optional macro INSTR_MEM_BYPASS_EN: same-cycle write    |
// |          data is forwarded to a read of the same address.        |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module instr_mem_dp
  import instr_mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int INIT_VALUE = DEF_INIT_VALUE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_valid,
  input  logic              rd2_req,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd2_data,
  output logic              rd2_valid,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              wr2_en,
  input  logic [ADDR_W-1:0] wr2_addr,
  input  logic [DATA_W-1:0] wr2_data,
  output logic              ready,
  output logic              wr_collision
);

  localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] c_init  = DATA_W'(INIT_VALUE);

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_t            r_state;
  logic [ADDR_W-1:0] r_fill_ptr;
  logic              r_ready;
  logic              r_wr_collision;

  logic              w_run;
  logic              w_wr1_ok;
  logic              w_wr2_ok;
  logic              w_same;
  logic              w_rd1_in;
  logic              w_rd2_in;
  logic [DATA_W-1:0] w_rd1_mem;
  logic [DATA_W-1:0] w_rd2_mem;
  logic [DATA_W-1:0] w_rd1_word;
  logic [DATA_W-1:0] w_rd2_word;

  assign w_run    = (r_state == ST_RUN);
  assign w_wr1_ok = w_run && wr1_en && ({1'b0, wr1_addr} < c_depth);
  assign w_wr2_ok = w_run && wr2_en && ({1'b0, wr2_addr} < c_depth);
  // Both writes land on one location: port 2 owns it.
  assign w_same   = w_wr1_ok && w_wr2_ok && (wr1_addr == wr2_addr);

  // Out-of-range reads are clamped to index 0 here; the read port zeroes them.
  assign w_rd1_in  = ({1'b0, rd1_addr} < c_depth);
  assign w_rd2_in  = ({1'b0, rd2_addr} < c_depth);
  assign w_rd1_mem = r_mem[w_rd1_in ? rd1_addr : '0];
  assign w_rd2_mem = r_mem[w_rd2_in ? rd2_addr : '0];

`ifdef INSTR_MEM_BYPASS_EN
  // Forward same-cycle write data; port 2 has priority as it wins the array.
  assign w_rd1_word = (w_wr2_ok && wr2_addr == rd1_addr) ? wr2_data :
                      (w_wr1_ok && wr1_addr == rd1_addr) ? wr1_data : w_rd1_mem;
  assign w_rd2_word = (w_wr2_ok && wr2_addr == rd2_addr) ? wr2_data :
                      (w_wr1_ok && wr1_addr == rd2_addr) ? wr1_data : w_rd2_mem;
`else
  assign w_rd1_word = w_rd1_mem;
  assign w_rd2_word = w_rd2_mem;
`endif

  // Array update: init fill walks the pointer, otherwise the two write ports.
  always_ff @(posedge clock) begin
    if (r_state == ST_FILL) begin
      r_mem[r_fill_ptr] <= c_init;
    end else begin
      if (w_wr1_ok && !w_same) begin
        r_mem[wr1_addr] <= wr1_data;
      end
      if (w_wr2_ok) begin
        r_mem[wr2_addr] <= wr2_data;
      end
    end
  end

  // Fill FSM with registered ready and collision pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_FILL;
      r_fill_ptr     <= '0;
      r_ready        <= 1'b0;
      r_wr_collision <= 1'b0;
    end else begin
      r_wr_collision <= w_same;
      case (r_state)
        ST_FILL: begin
          if (r_fill_ptr == c_last) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end else begin
            r_fill_ptr <= r_fill_ptr + 1'b1;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign ready        = r_ready;
  assign wr_collision = r_wr_collision;

  instr_mem_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_rd1 (
    .clock  (clock),
    .reset  (reset),
    .accept (rd1_req && w_run),
    .addr   (rd1_addr),
    .word   (w_rd1_word),
    .data   (rd1_data),
    .valid  (rd1_valid)
  );

  instr_mem_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_rd2 (
    .clock  (clock),
    .reset  (reset),
    .accept (rd2_req && w_run),
    .addr   (rd2_addr),
    .word   (w_rd2_word),
    .data   (rd2_data),
    .valid  (rd2_valid)
  );

endmodule : instr_mem_dp
`default_nettype wire

// File: tb/tb_instr_mem_dp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_instr_mem_dp                                         |
// | Brief  : Self-checking bench for instr_mem_dp (64-deep default   |
// |          instance plus a 40-deep instance for range handling).   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_instr_mem_dp;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        rd1_req = 0, rd2_req = 0, wr1_en = 0, wr2_en = 0;
  logic [5:0]  rd1_addr = 0, rd2_addr = 0, wr1_addr = 0, wr2_addr = 0;
  logic [15:0] wr1_data = 0, wr2_data = 0;
  logic [15:0] rd1_data, rd2_data;
  logic        rd1_valid, rd2_valid, ready, wr_collision;

  logic        d40_rd1_req = 0, d40_wr1_en = 0, d40_wr2_en = 0;
  logic [5:0]  d40_rd1_addr = 0, d40_wr1_addr = 0, d40_wr2_addr = 0;
  logic [15:0] d40_wr1_data = 0, d40_wr2_data = 0;
  logic [15:0] d40_rd1_data, d40_rd2_data;
  logic        d40_rd1_valid, d40_rd2_valid, d40_ready, d40_wr_collision;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic [15:0] q3[$];
  logic [15:0] exp_mem [64];
  logic [15:0] m1_exp, m2_exp, m3_exp;

  always #5 clock = ~clock;

  instr_mem_dp u_dut (
    .clock(clock), .reset(reset),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_valid(rd1_valid),
    .rd2_req(rd2_req), .rd2_addr(rd2_addr), .rd2_data(rd2_data), .rd2_valid(rd2_valid),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .wr2_en(wr2_en), .wr2_addr(wr2_addr), .wr2_data(wr2_data),
    .ready(ready), .wr_collision(wr_collision)
  );

  instr_mem_dp #(.DATA_W(16), .ADDR_W(6), .DEPTH(40), .INIT_VALUE(1)) u_dut40 (
    .clock(clock), .reset(reset),
    .rd1_req(d40_rd1_req), .rd1_addr(d40_rd1_addr), .rd1_data(d40_rd1_data), .rd1_valid(d40_rd1_valid),
    .rd2_req(1'b0), .rd2_addr(6'd0), .rd2_data(d40_rd2_data), .rd2_valid(d40_rd2_valid),
    .wr1_en(d40_wr1_en), .wr1_addr(d40_wr1_addr), .wr1_data(d40_wr1_data),
    .wr2_en(d40_wr2_en), .wr2_addr(d40_wr2_addr), .wr2_data(d40_wr2_data),
    .ready(d40_ready), .wr_collision(d40_wr_collision)
  );

  // Scoreboard monitors: each entry pushed before edge k must appear right after edge k.
  always @(posedge clock) begin
    #1;
    if (rd1_valid === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL rd1_spurious_valid: got valid=1 data=%h, required valid=0", rd1_data);
      end else begin
        m1_exp = q1.pop_front();
        if (rd1_data !== m1_exp) begin
          errors++;
          $display("FAIL rd1_data: got %h, required %h", rd1_data, m1_exp);
        end
      end
    end else if (q1.size() != 0) begin
      checks++; errors++;
      m1_exp = q1.pop_front();
      $display("FAIL rd1_valid: got %b, required 1 (expected data %h)", rd1_valid, m1_exp);
    end
  end

  always @(posedge clock) begin
    #1;
    if (rd2_valid === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL rd2_spurious_valid: got valid=1 data=%h, required valid=0", rd2_data);
      end else begin
        m2_exp = q2.pop_front();
        if (rd2_data !== m2_exp) begin
          errors++;
          $display("FAIL rd2_data: got %h, required %h", rd2_data, m2_exp);
        end
      end
    end else if (q2.size() != 0) begin
      checks++; errors++;
      m2_exp = q2.pop_front();
      $display("FAIL rd2_valid: got %b, required 1 (expected data %h)", rd2_valid, m2_exp);
    end
  end

  always @(posedge clock) begin
    #1;
    if (d40_rd1_valid === 1'b1) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL d40_rd1_spurious_valid: got valid=1 data=%h, required valid=0", d40_rd1_data);
      end else begin
        m3_exp = q3.pop_front();
        if (d40_rd1_data !== m3_exp) begin
          errors++;
          $display("FAIL d40_rd1_data: got %h, required %h", d40_rd1_data, m3_exp);
        end
      end
    end else if (q3.size() != 0) begin
      checks++; errors++;
      m3_exp = q3.pop_front();
      $display("FAIL d40_rd1_valid: got %b, required 1 (expected data %h)", d40_rd1_valid, m3_exp);
    end
  end

  task automatic drain();
    repeat (3) @(negedge clock);
    checks++;
    if (q1.size() != 0 || q2.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL drain: got pending %0d/%0d/%0d, required 0/0/0", q1.size(), q2.size(), q3.size());
      q1.delete(); q2.delete(); q3.delete();
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({rd1_data, rd2_data, rd1_valid, rd2_valid, ready, wr_collision} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h %h %b %b %b %b, required all 0",
               rd1_data, rd2_data, rd1_valid, rd2_valid, ready, wr_collision);
    end
    rd1_req = 1'b1; wr1_en = 1'b1; wr2_en = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({d40_rd1_data, d40_rd1_valid, d40_ready, d40_wr_collision, ready, rd1_valid} !== 21'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h %b %b %b %b %b, required all 0",
               d40_rd1_data, d40_rd1_valid, d40_ready, d40_wr_collision, ready, rd1_valid);
    end
    rd1_req = 1'b0; wr1_en = 1'b0; wr2_en = 1'b0;
  endtask

  task automatic test_fill();
    logic early;
    early = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clock);
      #1;
      if (k < 64 && ready !== 1'b0) early = 1'b1;
      if (k == 39) begin
        checks++;
        if (d40_ready !== 1'b0) begin
          errors++; $display("FAIL d40_ready_early: got %b at edge 39, required 0", d40_ready);
        end
      end
      if (k == 40) begin
        checks++;
        if (d40_ready !== 1'b1) begin
          errors++; $display("FAIL d40_ready_edge40: got %b, required 1", d40_ready);
        end
      end
    end
    checks++;
    if (early) begin
      errors++; $display("FAIL ready_early: got ready=1 before edge 64, required 0");
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL ready_edge64: got %b, required 1", ready);
    end
    for (int i = 0; i < 64; i++) exp_mem[i] = 16'h0001;
  endtask

  task automatic test_init_reads();
    logic [5:0] a [3];
    a[0] = 6'd0; a[1] = 6'd31; a[2] = 6'd63;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      rd1_req = 1'b1; rd1_addr = a[i]; q1.push_back(16'h0001);
      rd2_req = 1'b1; rd2_addr = a[2-i]; q2.push_back(16'h0001);
      @(negedge clock);
      rd1_req = 1'b0; rd2_req = 1'b0;
    end
    drain();
  endtask

  task automatic test_collision();
    @(negedge clock);
    wr1_en = 1'b1; wr1_addr = 6'd5; wr1_data = 16'hABCD;
    wr2_en = 1'b1; wr2_addr = 6'd5; wr2_data = 16'h1234;
    exp_mem[5] = 16'h1234;
    @(posedge clock); #1;
    checks++;
    if (wr_collision !== 1'b1) begin
      errors++; $display("FAIL collision_pulse: got %b, required 1", wr_collision);
    end
    @(negedge clock);
    wr1_addr = 6'd6; wr1_data = 16'hAAAA;
    wr2_addr = 6'd7; wr2_data = 16'h5555;
    exp_mem[6] = 16'hAAAA; exp_mem[7] = 16'h5555;
    @(posedge clock); #1;
    checks++;
    if (wr_collision !== 1'b0) begin
      errors++; $display("FAIL collision_clear: got %b, required 0", wr_collision);
    end
    @(negedge clock);
    wr1_en = 1'b0; wr2_en = 1'b0;
    for (int i = 5; i <= 7; i++) begin
      @(negedge clock);
      rd1_req = 1'b1; rd1_addr = 6'(i); q1.push_back(exp_mem[i]);
    end
    @(negedge clock);
    rd1_req = 1'b0;
    drain();
  endtask

  task automatic test_bypass();
    @(negedge clock);
    wr1_en = 1'b1; wr1_addr = 6'd9; wr1_data = 16'h00FF;
    rd1_req = 1'b1; rd1_addr = 6'd9;
`ifdef INSTR_MEM_BYPASS_EN
    q1.push_back(16'h00FF);
`else
    q1.push_back(16'h0001);
`endif
    exp_mem[9] = 16'h00FF;
    @(negedge clock);
    wr1_en = 1'b0;
    q1.push_back(16'h00FF);
    @(negedge clock);
    rd1_req = 1'b0;
    drain();
  endtask

  task automatic test_out_of_range();
    @(negedge clock);
    d40_wr1_en = 1'b1; d40_wr1_addr = 6'd50; d40_wr1_data = 16'hBEEF;
    d40_wr2_en = 1'b1; d40_wr2_addr = 6'd50; d40_wr2_data = 16'hBEEF;
    @(posedge clock); #1;
    checks++;
    if (d40_wr_collision !== 1'b0) begin
      errors++; $display("FAIL oor_collision: got %b, required 0", d40_wr_collision);
    end
    @(negedge clock);
    d40_wr1_en = 1'b0; d40_wr2_en = 1'b0;
    d40_rd1_req = 1'b1; d40_rd1_addr = 6'd50; q3.push_back(16'h0000);
    @(negedge clock);
    d40_rd1_addr = 6'd63; q3.push_back(16'h0000);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      d40_rd1_addr = 6'(i); q3.push_back(16'h0001);
    end
    @(negedge clock);
    d40_rd1_req = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      rd1_req = 1'b1; rd1_addr = 6'(i);     q1.push_back(exp_mem[i]);
      rd2_req = 1'b1; rd2_addr = 6'(9 - i); q2.push_back(exp_mem[9 - i]);
    end
    @(negedge clock);
    rd1_req = 1'b0; rd2_req = 1'b0;
    drain();
    checks++;
    if (rd1_data !== exp_mem[9] || rd2_data !== exp_mem[0] || rd1_valid !== 1'b0 || rd2_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold: got %h/%h v%b%b, required %h/%h v00",
               rd1_data, rd2_data, rd1_valid, rd2_valid, exp_mem[9], exp_mem[0]);
    end
  endtask

  task automatic test_fill_reset();
    logic early;
    logic coll;
    early = 1'b0; coll = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if ({ready, rd1_valid, rd2_valid, rd1_data, rd2_data} !== 35'd0) begin
      errors++; $display("FAIL midfill_reset: got ready=%b data %h/%h, required all 0", ready, rd1_data, rd2_data);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clock);
      #1;
      if (k < 64 && ready !== 1'b0) early = 1'b1;
      if (wr_collision !== 1'b0) coll = 1'b1;
      @(negedge clock);
      if (k < 60) begin
        rd1_req = 1'b1; rd1_addr = 6'(k);
        rd2_req = 1'b1; rd2_addr = 6'(63 - k);
        wr1_en = 1'b1; wr1_addr = 6'd3; wr1_data = 16'hDEAD;
        wr2_en = 1'b1; wr2_addr = 6'd3; wr2_data = 16'hFACE;
      end else begin
        rd1_req = 1'b0; rd2_req = 1'b0; wr1_en = 1'b0; wr2_en = 1'b0;
      end
    end
    checks++;
    if (early || coll) begin
      errors++; $display("FAIL refill_gating: got early_ready=%b collision=%b, required 0/0", early, coll);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL refill_ready: got %b, required 1", ready);
    end
    for (int i = 0; i < 64; i++) exp_mem[i] = 16'h0001;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      rd1_req = 1'b1; rd1_addr = 6'(i);      q1.push_back(exp_mem[i]);
      rd2_req = 1'b1; rd2_addr = 6'(63 - i); q2.push_back(exp_mem[63 - i]);
    end
    @(negedge clock);
    rd1_req = 1'b0; rd2_req = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_init_reads();
    test_collision();
    test_bypass();
    test_out_of_range();
    test_back_to_back();
    test_fill_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_instr_mem_dp
`default_nettype wire
